if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000: instruction word presented for a bubble.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 stall  in  1  downstream hazard hold; decode-side register must not advance.
REQ-006 branch_taken  in  1  one-cycle redirect pulse from the branch unit.
REQ-007 branch_target  in  32  redirect PC, valid while branch_taken=1.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  32  read address; word aligned.
REQ-010 imem_ready  in  1  read completes this cycle; imem_rdata valid.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 if_inst  out  32  registered instruction to decode.
REQ-013 if_pc4  out  32  registered PC+4 of if_inst.
REQ-014 if_valid  out  1  if_inst is a real fetched instruction, not a bubble.
REQ-015 IF_ins_type  out  4  opcode class of if_inst.
REQ-016 IF_ins_number  out  4  sequence number of if_inst.

Function
REQ-017 The FSM SHALL have states BOOT, REQ, HOLD, DRAIN; BOOT lasts exactly one cycle after reset release, emits a bubble, then goes to REQ.
REQ-018 In REQ and DRAIN, imem_req=1; imem_addr SHALL stay stable from assertion until the cycle imem_ready=1.
REQ-019 In HOLD and BOOT, imem_req=0.
REQ-020 REQ, imem_ready=1, stall=0, branch_taken=0: capture imem_rdata into if_inst, if_pc4=pc+4, if_valid=1, pc<=pc+4, IF_ins_number increments; stay in REQ; fetch-to-output latency is one cycle.
REQ-021 REQ, imem_ready=1, stall=1: word goes into a one-entry skid buffer, outputs hold, go to HOLD.
REQ-022 HOLD, stall=0: skid word goes to the outputs as in REQ-020, then go to REQ.
REQ-023 stall=1 with no completing read: all outputs and pc hold.
REQ-024 branch_taken SHALL take priority over stall and over a completing read.
  - On branch_taken: pc<=branch_target and the outputs become a bubble (if_inst=NOP_INST, if_valid=0, IF_ins_type=0, IF_ins_number unchanged).
  - A word completing in the same cycle is discarded.
  - In HOLD, the skid buffer is discarded and the state goes to REQ.
REQ-025 branch_taken in REQ while a read is outstanding (imem_ready=0): go to DRAIN, keep the old address until imem_ready, discard that data, then fetch from the saved target in REQ.
REQ-026 A second branch_taken during DRAIN SHALL overwrite the saved target.
REQ-027 IF_ins_type SHALL decode opcode bits [31:26] as follows:
  - R-type 000000 -> 1; lw -> 3; sw -> 4; beq -> 5; bne -> 6; j -> 7.
  - addi/andi/ori/slti/lui -> 2; any other opcode -> 15.
  - A bubble -> 0; an all-zero valid word -> 1.
REQ-028 IF_ins_number SHALL wrap 15->0 without error; pc SHALL wrap modulo 2^32.
REQ-029 Bit pattern imem_rdata is not checked; misaligned branch_target[1:0] SHALL be forced to 00.

Reset
REQ-030 While rst=0 the block SHALL reset asynchronously:
  - pc=RESET_PC, state=BOOT, skid buffer empty.
  - imem_req=0, if_inst=NOP_INST, if_pc4=0, if_valid=0, IF_ins_type=0, IF_ins_number=0.
REQ-031 Reset asserted mid-read SHALL abandon the read; any later imem_ready SHALL be ignored until the next REQ.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the IF_ins_type class constants and the opcode constants, reused by decode and control.
REQ-033 One sub-module, inst_classify (combinational opcode -> IF_ins_type), SHALL be instantiated; everything else lives in if_stage.

Verification
REQ-034 Reset then zero-wait memory: cycle 1 is a bubble; the next four outputs have if_pc4 = 4, 8, C, 10 and IF_ins_number = 1..4.
REQ-035 stall=1 for 3 cycles while a read completes: outputs hold; after release, the buffered word appears with no re-fetch (exactly one imem_req handshake for it).
REQ-036 branch_taken with target 32'h40 while a read is pending 2 wait-states: DRAIN discards the old word; the next valid output has if_pc4=32'h44.
REQ-037 branch_taken and stall in the same cycle: bubble is output, pc=target, IF_ins_number unchanged.
REQ-038 Fetch 17 instructions: IF_ins_number wraps to 0 then 1; IF_ins_type matches for lw(3), sw(4), beq(5), j(7), and 6'b111111 gives 15.
REQ-039 rst=0 during a wait-state read: outputs reset immediately, and a stray imem_ready after release is ignored.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: fetch FSM encoding, opcode values, instruction classes.
// No logic; constants and types only.
// Imported by the fetch stage and its opcode classifier.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] CLS_BUBBLE = 4'd0;
    localparam logic [3:0] CLS_R      = 4'd1;
    localparam logic [3:0] CLS_IMM    = 4'd2;
    localparam logic [3:0] CLS_LW     = 4'd3;
    localparam logic [3:0] CLS_SW     = 4'd4;
    localparam logic [3:0] CLS_BEQ    = 4'd5;
    localparam logic [3:0] CLS_BNE    = 4'd6;
    localparam logic [3:0] CLS_J      = 4'd7;
    localparam logic [3:0] CLS_OTHER  = 4'd15;

endpackage

// File: rtl/if_stage_inst_classify.sv
// Maps an instruction opcode to its class code; bubbles map to class 0.
// Latency: purely combinational.
// Backpressure: none.
module inst_classify
    import if_stage_pkg::*;
(
    input  logic       valid,
    input  logic [5:0] opcode,
    output logic [3:0] ins_type
);

    always_comb begin
        ins_type = CLS_OTHER;
        case (opcode)
            OP_RTYPE: ins_type = CLS_R;
            OP_LW:    ins_type = CLS_LW;
            OP_SW:    ins_type = CLS_SW;
            OP_BEQ:   ins_type = CLS_BEQ;
            OP_BNE:   ins_type = CLS_BNE;
            OP_J:     ins_type = CLS_J;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: ins_type = CLS_IMM;
            default:  ins_type = CLS_OTHER;
        endcase
        if (!valid)
            ins_type = CLS_BUBBLE;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC sequencing, imem request handshake, branch redirect, decode register.
// Latency: one cycle from completing read to if_inst; one bubble cycle after reset release.
// Backpressure: stall parks a completed word in a one-entry skid buffer; branch overrides stall.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_inst;
    logic [31:0] drain_tgt;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;

    assign tgt       = branch_target & ~32'd3;
    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_BOOT;
            pc            <= RESET_PC;
            skid_inst     <= '0;
            drain_tgt     <= '0;
            if_inst       <= NOP_INST;
            if_pc4        <= '0;
            if_valid      <= 1'b0;
            IF_ins_number <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    if_inst  <= NOP_INST;
                    if_valid <= 1'b0;
                    if (branch_taken)
                        pc <= tgt;
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (branch_taken) begin
                        if_inst  <= NOP_INST;
                        if_valid <= 1'b0;
                        if (imem_ready) begin
                            pc <= tgt;
                        end else begin
                            // Read still in flight: address must stay put until it retires.
                            drain_tgt <= tgt;
                            state     <= ST_DRAIN;
                        end
                    end else if (imem_ready) begin
                        pc <= pc_plus4;
                        if (stall) begin
                            skid_inst <= imem_rdata;
                            state     <= ST_HOLD;
                        end else begin
                            if_inst       <= imem_rdata;
                            if_pc4        <= pc_plus4;
                            if_valid      <= 1'b1;
                            IF_ins_number <= IF_ins_number + 4'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        if_inst  <= NOP_INST;
                        if_valid <= 1'b0;
                        pc       <= tgt;
                        state    <= ST_REQ;
                    end else if (!stall) begin
                        // pc already advanced past the parked word, so it is that word's PC+4.
                        if_inst       <= skid_inst;
                        if_pc4        <= pc;
                        if_valid      <= 1'b1;
                        IF_ins_number <= IF_ins_number + 4'd1;
                        state         <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (branch_taken) begin
                        if_inst   <= NOP_INST;
                        if_valid  <= 1'b0;
                        drain_tgt <= tgt;
                    end
                    if (imem_ready) begin
                        pc    <= branch_taken ? tgt : drain_tgt;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    inst_classify u_classify (
        .valid    (if_valid),
        .opcode   (if_inst[31:26]),
        .ins_type (IF_ins_type)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an address-derived instruction memory.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'hDEAD_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [3:0]  IF_ins_type;
    logic [3:0]  IF_ins_number;

    int          errs = 0;
    int          checks = 0;
    int          hs = 0;
    logic [31:0] hs_addr = 32'hFFFF_FFFF;
    logic [5:0]  opc   [0:31];
    logic [3:0]  etype [0:31];

    if_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_inst       (if_inst),
        .if_pc4        (if_pc4),
        .if_valid      (if_valid),
        .IF_ins_type   (IF_ins_type),
        .IF_ins_number (IF_ins_number)
    );

    always #5 clk = ~clk;

    assign imem_rdata = {opc[imem_addr[6:2]], imem_addr[25:0]};

    always @(posedge clk)
        if (imem_req && imem_ready && imem_addr == hs_addr)
            hs = hs + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag, input logic [3:0] num);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_inst"},  if_inst, NOP);
        chk({tag, "_type"},  {28'd0, IF_ins_type}, 32'd0);
        chk({tag, "_num"},   {28'd0, IF_ins_number}, {28'd0, num});
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr, input logic [3:0] num);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        chk({tag, "_pc4"},   if_pc4, addr + 32'd4);
        chk({tag, "_inst"},  if_inst, {opc[addr[6:2]], addr[25:0]});
        chk({tag, "_num"},   {28'd0, IF_ins_number}, {28'd0, num});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            opc[i]   = 6'b001000;
            etype[i] = 4'd2;
        end
        opc[4]  = 6'b100011; etype[4]  = 4'd3;
        opc[5]  = 6'b101011; etype[5]  = 4'd4;
        opc[6]  = 6'b000100; etype[6]  = 4'd5;
        opc[7]  = 6'b000010; etype[7]  = 4'd7;
        opc[8]  = 6'b111111; etype[8]  = 4'd15;
        opc[9]  = 6'b000000; etype[9]  = 4'd1;
        opc[10] = 6'b000101; etype[10] = 4'd6;
        opc[11] = 6'b001111; etype[11] = 4'd2;

        // Reset state
        tick;
        tick;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc4", if_pc4, 32'd0);
        chk_bubble("rst", 4'd0);

        // Zero-wait memory: one boot bubble, then back-to-back fetches with wrap of the sequence number
        imem_ready = 1'b1;
        rst = 1'b1;
        tick;
        chk_bubble("boot", 4'd0);
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        for (int k = 1; k <= 17; k++) begin
            tick;
            chk_fetch($sformatf("seq%0d", k), 32'(4 * (k - 1)), 4'(k));
            chk($sformatf("seq%0d_type", k), {28'd0, IF_ins_type}, {28'd0, etype[k - 1]});
        end

        // Stall while a read completes: word is parked, outputs frozen, no re-fetch
        hs_addr = 32'h44;
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick;
            chk($sformatf("stall%0d_pc4", s), if_pc4, 32'h44);
            chk($sformatf("stall%0d_num", s), {28'd0, IF_ins_number}, 32'd1);
            chk($sformatf("stall%0d_valid", s), {31'd0, if_valid}, 32'd1);
            chk($sformatf("stall%0d_req", s), {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        imem_ready = 1'b0;
        tick;
        chk_fetch("skid", 32'h44, 4'd2);
        chk("skid_addr", imem_addr, 32'h48);
        chk("skid_hs", 32'(hs), 32'd1);

        // Branch during an outstanding read, re-targeted during DRAIN, misaligned targets
        tick;
        branch_taken = 1'b1;
        branch_target = 32'h61;
        tick;
        chk_bubble("drain", 4'd2);
        chk("drain_addr0", imem_addr, 32'h48);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        branch_target = 32'h43;
        tick;
        chk("drain_addr1", imem_addr, 32'h48);
        branch_taken = 1'b0;
        imem_ready = 1'b1;
        tick;
        chk("drain_done_addr", imem_addr, 32'h40);
        chk("drain_done_valid", {31'd0, if_valid}, 32'd0);
        tick;
        chk_fetch("tgt", 32'h40, 4'd3);

        // Branch and stall together with a completing read
        branch_taken = 1'b1;
        branch_target = 32'h80;
        stall = 1'b1;
        tick;
        chk_bubble("brstall", 4'd3);
        chk("brstall_addr", imem_addr, 32'h80);
        branch_taken = 1'b0;
        stall = 1'b0;
        tick;
        chk_fetch("after_br", 32'h80, 4'd4);

        // Reset during a wait-state read, stray ready after release
        imem_ready = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        chk_bubble("async_rst", 4'd0);
        chk("async_rst_pc4", if_pc4, 32'd0);
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        tick;
        rst = 1'b1;
        imem_ready = 1'b1;
        tick;
        chk_bubble("stray", 4'd0);
        chk("stray_addr", imem_addr, 32'd0);
        imem_ready = 1'b0;
        tick;
        chk_bubble("wait0", 4'd0);
        imem_ready = 1'b1;
        tick;
        chk_fetch("refetch", 32'h0, 4'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
